// File: rtl/dbg_counter_unit.sv
// Debug event counters for AXI master handshakes and PairHMM job/result strobes,
// with outstanding read/write trackers, synchronous clear and a freeze snapshot.
module dbg_counter_unit #(
    parameter int CNT_WIDTH   = 32,
    parameter int OUTST_WIDTH = 16,
    parameter bit SATURATE    = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arvalid_i,
    input  logic                   arready_i,
    input  logic                   rvalid_i,
    input  logic                   rready_i,
    input  logic                   rlast_i,
    input  logic                   awvalid_i,
    input  logic                   awready_i,
    input  logic                   bvalid_i,
    input  logic                   bready_i,
    input  logic                   job_created_i,
    input  logic                   result_wb_i,
    input  logic                   clear_i,
    input  logic                   freeze_i,
    output logic [CNT_WIDTH-1:0]   axi_read_issued_o,
    output logic [CNT_WIDTH-1:0]   axi_read_resp_o,
    output logic [CNT_WIDTH-1:0]   axi_write_issued_o,
    output logic [CNT_WIDTH-1:0]   axi_write_resp_o,
    output logic [CNT_WIDTH-1:0]   jobs_created_o,
    output logic [CNT_WIDTH-1:0]   results_to_wb_o,
    output logic [OUTST_WIDTH-1:0] outstanding_rd_o,
    output logic [OUTST_WIDTH-1:0] outstanding_wr_o,
    output logic                   underflow_err_o,
    output logic                   frozen_o
);
    typedef enum logic {S_LIVE = 1'b0, S_FROZEN = 1'b1} state_t;
    localparam int NCNT = 6;

    logic                   w_rd_iss, w_rd_cmp, w_wr_iss, w_wr_cmp;
    logic                   w_rd_uf, w_wr_uf;
    logic [NCNT-1:0]        w_ev;
    logic [CNT_WIDTH-1:0]   w_cnt_nxt [NCNT];
    logic [OUTST_WIDTH-1:0] w_ord_nxt, w_owr_nxt;

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_cnt [NCNT];
    // Mirrors r_cnt while live; holds the snapshot while frozen.
    logic [CNT_WIDTH-1:0]   r_out [NCNT];
    logic [OUTST_WIDTH-1:0] r_ord, r_owr;
    logic                   r_err;

    assign w_rd_iss = arvalid_i & arready_i;
    assign w_rd_cmp = rvalid_i & rready_i & rlast_i;
    assign w_wr_iss = awvalid_i & awready_i;
    assign w_wr_cmp = bvalid_i & bready_i;
    assign w_ev     = {result_wb_i, job_created_i, w_wr_cmp, w_wr_iss, w_rd_cmp, w_rd_iss};

    // Returns {underflow, next tracker value}; sticks at max on issue, at 0 on completion.
    function automatic logic [OUTST_WIDTH:0] trk_nxt(input logic [OUTST_WIDTH-1:0] v,
                                                     input logic iss, input logic cmp);
        logic [OUTST_WIDTH-1:0] nv;
        logic                   uf;
        nv = v;
        uf = 1'b0;
        if (iss && !cmp) begin
            if (!(&v)) nv = v + OUTST_WIDTH'(1);
        end else if (!iss && cmp) begin
            if (v == '0) uf = 1'b1;
            else         nv = v - OUTST_WIDTH'(1);
        end
        return {uf, nv};
    endfunction

    assign {w_rd_uf, w_ord_nxt} = trk_nxt(r_ord, w_rd_iss, w_rd_cmp);
    assign {w_wr_uf, w_owr_nxt} = trk_nxt(r_owr, w_wr_iss, w_wr_cmp);

    always_comb begin
        for (int i = 0; i < NCNT; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_ev[i] && !(SATURATE && (&r_cnt[i])))
                w_cnt_nxt[i] = r_cnt[i] + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LIVE;
            r_ord   <= '0;
            r_owr   <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < NCNT; i++) begin
                r_cnt[i] <= '0;
                r_out[i] <= '0;
            end
        end else if (clear_i) begin
            // Same-cycle events are dropped; a same-cycle freeze snapshots zeroes.
            r_state <= freeze_i ? S_FROZEN : S_LIVE;
            r_ord   <= '0;
            r_owr   <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < NCNT; i++) begin
                r_cnt[i] <= '0;
                r_out[i] <= '0;
            end
        end else begin
            r_state <= freeze_i ? S_FROZEN : S_LIVE;
            r_ord   <= w_ord_nxt;
            r_owr   <= w_owr_nxt;
            r_err   <= r_err | w_rd_uf | w_wr_uf;
            for (int i = 0; i < NCNT; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
                if (!freeze_i || r_state == S_LIVE)
                    r_out[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign axi_read_issued_o  = r_out[0];
    assign axi_read_resp_o    = r_out[1];
    assign axi_write_issued_o = r_out[2];
    assign axi_write_resp_o   = r_out[3];
    assign jobs_created_o     = r_out[4];
    assign results_to_wb_o    = r_out[5];
    assign outstanding_rd_o   = r_ord;
    assign outstanding_wr_o   = r_owr;
    assign underflow_err_o    = r_err;
    assign frozen_o           = (r_state == S_FROZEN);
endmodule
